// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_pkg
// Purpose  : Shared constants for the multiplexed seven-segment scanner:
//            hex-to-segment table, blank patterns and digit-index width.
// Revision : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

  // Digit index width (eight digits)
  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  // Active-low "everything dark" patterns
  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low segment codes, dp bit (7) off; entry n is the glyph for nibble n
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage
`default_nettype wire

// File: rtl/seven_seg_scan_hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Purpose  : Combinational nibble + decimal point to active-low segments.
//            seg_o[6:0] = g..a, seg_o[7] = dp (0 = lit).
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_i,
  output logic [7:0] seg_o
);

  // Table lookup, then pull the dp bit low when the point is requested
  always_comb begin
    seg_o = HEX_SEG[nib_i] & ~{dp_i, 7'b000_0000};
  end

endmodule
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Purpose  : Eight-digit time-multiplexed seven-segment driver. A prescaler
//            sets the slot length; inputs are captured into a frame buffer
//            at frame wrap, on load_now, or right after reset, so a frame is
//            never torn. an/seg are registered and active-low.
// Options  : define SEVEN_SEG_LEADING_ZERO_BLANK_EN to darken digits above
//            the highest nonzero buffered nibble (digit 0 always shown).
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000   // clk cycles per digit slot, 2..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] disp_num,
  input  logic [7:0]  point_en,
  input  logic [7:0]  blank,
  input  logic        load_now,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam logic [15:0] PRESC_LAST = 16'(SCAN_DIV - 1);

  logic [15:0]      presc_q, presc_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [31:0]      num_q,   num_d;
  logic [7:0]       pt_q,    pt_d;
  logic [7:0]       blk_q,   blk_d;
  logic             pend_q,  pend_d;
  logic             fd_q,    fd_d;
  logic [7:0]       an_q,    an_d;
  logic [7:0]       seg_q,   seg_d;

  logic             tick;
  logic             load;
  logic             lz_dark;
  logic             dark;
  logic [3:0]       cur_nib;
  logic [7:0]       cur_seg;

  assign tick    = (presc_q == PRESC_LAST);
  // Wrap-load and load_now collapse into one capture; pending covers reset exit
  assign load    = pend_q | load_now | (tick & (idx_q == IDX_LAST));
  assign cur_nib = num_q[{idx_q, 2'b00} +: 4];

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Digit is a leading zero when it and every nibble above it are zero
  assign lz_dark = (idx_q != '0) && ((num_q >> {idx_q, 2'b00}) == 32'd0);
`else
  assign lz_dark = 1'b0;
`endif

  assign dark = blk_q[idx_q] | lz_dark;

  hex7seg u_hex7seg (
    .nib_i (cur_nib),
    .dp_i  (pt_q[idx_q]),
    .seg_o (cur_seg)
  );

  // Next-state: prescaler/index advance, frame capture, registered drive values
  always_comb begin
    presc_d = tick ? 16'd0 : presc_q + 16'd1;
    idx_d   = tick ? idx_q + 1'b1 : idx_q;
    num_d   = num_q;
    pt_d    = pt_q;
    blk_d   = blk_q;
    pend_d  = pend_q & ~load;
    fd_d    = load;
    if (load) begin
      num_d = disp_num;
      pt_d  = point_en;
      blk_d = blank;
    end
    an_d  = dark ? AN_OFF  : ~(8'b0000_0001 << idx_q);
    seg_d = dark ? SEG_OFF : cur_seg;
  end

  // State register with synchronous reset; reset forces a capture on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= 16'd0;
      idx_q   <= '0;
      num_q   <= 32'd0;
      pt_q    <= 8'd0;
      blk_q   <= 8'd0;
      pend_q  <= 1'b1;
      fd_q    <= 1'b0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      num_q   <= num_d;
      pt_q    <= pt_d;
      blk_q   <= blk_d;
      pend_q  <= pend_d;
      fd_q    <= fd_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan
// Purpose  : Self-checking bench for seven_seg_scan with SCAN_DIV = 4.
//            Table-driven slot checks, directed corner sequences and a
//            randomized run against a cycle-count based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] disp_num = 32'd0;
  logic [7:0]  point_en = 8'd0;
  logic [7:0]  blank    = 8'd0;
  logic        load_now = 1'b0;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  seven_seg_scan #(.SCAN_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_num   (disp_num),
    .point_en   (point_en),
    .blank      (blank),
    .load_now   (load_now),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: edges since reset release, pending flag, captured frame
  int          m_cnt  = 0;
  bit          m_pend = 1'b1;
  logic [31:0] m_num  = 32'd0;
  logic [7:0]  m_pt   = 8'd0;
  logic [7:0]  m_blk  = 8'd0;
  logic [7:0]  exp_an, exp_seg;
  logic        exp_fd;

  typedef struct {
    logic [31:0] num;
    logic [7:0]  pt;
    logic [7:0]  blk;
    int          digit;
    logic [7:0]  x_an;
    logic [7:0]  x_seg;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  task automatic ref_digit(input int d, input logic [31:0] num, input logic [7:0] pt,
                           input logic [7:0] blk, output logic [7:0] o_an, output logic [7:0] o_seg);
    bit dk;
    logic [3:0] nib;
    dk = blk[d];
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    begin
      int hi;
      hi = 0;
      for (int i = 0; i < 8; i++) if (((num >> (4 * i)) & 32'hF) != 0) hi = i;
      if (d > hi) dk = 1'b1;
    end
`endif
    nib = 4'((num >> (4 * d)) & 32'hF);
    if (dk) begin
      o_an  = 8'hFF;
      o_seg = 8'hFF;
    end else begin
      o_an  = ~(8'h01 << d);
      o_seg = glyph(nib) & (pt[d] ? 8'h7F : 8'hFF);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  // One clock: predict from current inputs, clock, then compare all outputs
  task automatic step();
    int  d;
    bit  ld;
    if (rst) begin
      exp_an = 8'hFF; exp_seg = 8'hFF; exp_fd = 1'b0;
      m_cnt = 0; m_pend = 1'b1; m_num = '0; m_pt = '0; m_blk = '0;
    end else begin
      d = (m_cnt / DIV) % 8;
      ref_digit(d, m_num, m_pt, m_blk, exp_an, exp_seg);
      ld = m_pend || load_now || (((m_cnt % DIV) == DIV - 1) && d == 7);
      exp_fd = ld;
      if (ld) begin
        m_num = disp_num; m_pt = point_en; m_blk = blank; m_pend = 1'b0;
      end
      m_cnt++;
    end
    @(posedge clk);
    #1;
    check8("an", an, exp_an);
    check8("seg", seg, exp_seg);
    check8("frame_done", {7'd0, frame_done}, {7'd0, exp_fd});
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 200 && m_cnt < target; k++) step();
    check_int("run_to_reached", m_cnt, target);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int pulses;

    // AA5555AA: digit k sampled late in its slot (edge 4k+3)
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 0, 8'hFE, 8'h88});
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 1, 8'hFD, 8'h88});
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 2, 8'hFB, 8'h92});
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 3, 8'hF7, 8'h92});
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 4, 8'hEF, 8'h92});
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 5, 8'hDF, 8'h92});
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 6, 8'hBF, 8'h88});
    vecs.push_back('{32'hAA5555AA, 8'h00, 8'h00, 7, 8'h7F, 8'h88});
    vecs.push_back('{32'h000000F0, 8'h00, 8'h00, 0, 8'hFE, 8'hC0});
    vecs.push_back('{32'h000000F0, 8'h00, 8'h00, 1, 8'hFD, 8'h8E});
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    vecs.push_back('{32'h000000F0, 8'h00, 8'h00, 2, 8'hFF, 8'hFF});
    vecs.push_back('{32'h000000F0, 8'h00, 8'h00, 7, 8'hFF, 8'hFF});
`else
    vecs.push_back('{32'h000000F0, 8'h00, 8'h00, 2, 8'hFB, 8'hC0});
    vecs.push_back('{32'h000000F0, 8'h00, 8'h00, 7, 8'h7F, 8'hC0});
`endif
    vecs.push_back('{32'h00000008, 8'h01, 8'h80, 0, 8'hFE, 8'h00});
    vecs.push_back('{32'h00000008, 8'h01, 8'h80, 7, 8'hFF, 8'hFF});

    // Reset state
    rst = 1'b1;
    step();
    check8("reset_an", an, 8'hFF);
    check8("reset_seg", seg, 8'hFF);
    check8("reset_fd", {7'd0, frame_done}, 8'h00);

    // frame_done pulses exactly once right after reset release
    disp_num = 32'hAA5555AA;
    do_reset();
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      pulses += int'(frame_done);
    end
    check_int("post_reset_pulses", pulses, 1);

    // Table-driven slot checks
    foreach (vecs[i]) begin
      disp_num = vecs[i].num;
      point_en = vecs[i].pt;
      blank    = vecs[i].blk;
      do_reset();
      run_to(4 * vecs[i].digit + 3);
      check8($sformatf("vec%0d_an", i), an, vecs[i].x_an);
      check8($sformatf("vec%0d_seg", i), seg, vecs[i].x_seg);
    end
    point_en = 8'h00;
    blank    = 8'h00;

    // Input change mid-frame does not tear the frame
    disp_num = 32'h12345678;
    do_reset();
    run_to(13);
    disp_num = 32'h9ABCDEF0;
    run_to(19); check8("tear_d4", seg, 8'h99);
    run_to(23); check8("tear_d5", seg, 8'hB0);
    run_to(27); check8("tear_d6", seg, 8'hA4);
    run_to(31); check8("tear_d7", seg, 8'hF9);
    run_to(35); check8("newframe_d0_seg", seg, 8'hC0);
    check8("newframe_d0_an", an, 8'hFE);

    // load_now coincident with the index-7 tick
    disp_num = 32'h11111111;
    do_reset();
    run_to(31);
    disp_num = 32'hCAFE0123;
    load_now = 1'b1;
    step();
    load_now = 1'b0;
    disp_num = 32'h88888888;
    pulses = int'(frame_done);
    for (int k = 0; k < 3; k++) begin
      step();
      pulses += int'(frame_done);
    end
    check_int("coincident_pulses", pulses, 1);
    check8("coincident_d0_seg", seg, 8'hB0);

    // One-cycle reset during digit 5
    disp_num = 32'h12345678;
    do_reset();
    run_to(22);
    rst = 1'b1;
    step();
    check8("midrst_an", an, 8'hFF);
    check8("midrst_seg", seg, 8'hFF);
    rst = 1'b0;
    step();
    check8("midrst_capture_fd", {7'd0, frame_done}, 8'h01);
    step();
    check8("midrst_d0_an", an, 8'hFE);
    check8("midrst_d0_seg", seg, 8'h80);

    // Randomized run against the reference model
    for (int k = 0; k < 3000; k++) begin
      disp_num = $urandom >> (4 * $urandom_range(0, 7));
      point_en = 8'($urandom);
      blank    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      load_now = ($urandom_range(0, 15) == 0);
      rst      = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    load_now = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 Parameter SCAN_DIV, default 50000, clk cycles per digit slot; legal range 2..65535.
REQ-002 clk  input  1  single system clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 disp_num  input  32  value to display; nibble i shows on digit i (digit 0 = bits 3:0).
REQ-005 point_en  input  8  decimal point request per digit, 1 = lit.
REQ-006 blank  input  8  per-digit blank mask, 1 = digit dark.
REQ-007 load_now  input  1  one-cycle request to capture inputs immediately.
REQ-008 an  output  8  digit enables, active-low, at most one bit low at a time.
REQ-009 seg  output  8  segments, active-low; seg[6:0] = g..a, seg[7] = dp.
REQ-010 frame_done  output  1  one-cycle pulse on every capture of the inputs.

Function
REQ-011 Prescaler counts 0..SCAN_DIV-1 and wraps; tick = (prescaler == SCAN_DIV-1).
REQ-012 On tick, the 3-bit digit index increments, wrapping 7 -> 0.
REQ-013 Frame buffer (disp_num, point_en, blank) loads on tick with index == 7, so the new digit 0 uses new data; no tearing inside a frame.
REQ-014 Buffer also loads on load_now, and on the first cycle after rst deasserts (pending-load flag set by reset).
REQ-015 Simultaneous load_now and wrap-load produce a single capture and a single frame_done pulse.
REQ-016 frame_done is registered and asserts in the cycle after the capturing edge.
REQ-017 an/seg are registered: they reflect the index and buffer one clk after the index update.
REQ-018 Hex decode, active-low with dp off: 0 -> C0, 1 -> F9, 2 -> A4, 3 -> B0, 4 -> 99, 5 -> 92, 6 -> 82, 7 -> F8, 8 -> 80, 9 -> 90, A -> 88, b -> 83, C -> C6, d -> A1, E -> 86, F -> 8E.
REQ-019 A lit dp clears seg[7].
REQ-020 A blanked digit drives an = FF and seg = FF during its slot; the slot timing is unchanged.
REQ-021 Input changes between captures have no effect on an/seg.

Reset
REQ-022 While rst is high: an = FF, seg = FF, frame_done = 0, prescaler = 0, index = 0, buffer = 0, pending-load = 1.
REQ-023 rst asserted mid-frame takes effect at the next edge and overrides load_now and tick.

Configuration
REQ-024 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN.
- Defined: digits above the highest nonzero buffered nibble are treated as blanked; digit 0 is never blanked by this rule.
- Undefined: all eight digits display, including leading zeros.
- The blank input is honoured in both builds.

Structure
REQ-025 Shared package seven_seg_pkg holds:
- the 16-entry hex-to-segment constant table (REQ-018);
- SEG_OFF = 8'hFF;
- AN_OFF = 8'hFF;
- the digit-index width constant (3).
REQ-026 One sub-module, hex7seg: combinational nibble + dp -> seg; no other sub-modules.

Verification (SCAN_DIV = 4)
REQ-027 Reset, then disp_num = AA5555AA held:
- frame_done pulses once just after reset;
- on successive 4-cycle slots, (an, seg) = (FE, 88), (FD, 88), (FB, 92), (F7, 92), (EF, 92), (DF, 92), (BF, 88), (7F, 88).
REQ-028 disp_num changes 12345678 -> 9ABCDEF0 during digit 3:
- digits 4..7 still show 4, 3, 2, 1 (99, B0, A4, F9);
- the next frame's digit 0 shows 0 (C0).
REQ-029 load_now on the same cycle as the index-7 tick:
- exactly one frame_done pulse;
- buffer holds that cycle's disp_num.
REQ-030 With SEVEN_SEG_LEADING_ZERO_BLANK_EN, disp_num = 000000F0:
- digits 2..7 are dark (an = FF, seg = FF);
- digit 1 = 8E, digit 0 = C0.
- Without the macro, digits 2..7 show C0.
REQ-031 point_en = 01, blank = 80, disp_num = 00000008:
- digit 0 seg = 00;
- digit 7 slot an = FF.
REQ-032 rst pulsed for one cycle during digit 5:
- next cycle an = FF, seg = FF, index = 0;
- the following cycle captures inputs and frame_done pulses.
